// File: rtl/s_screen_par.sv
// SPI driver for a page-addressed monochrome OLED panel: power sequencing, init command list,
// then frames of window commands plus COLS*PAGES bytes streamed from an external frame buffer.
module s_screen_par #(
   parameter int COLS         = 128,
   parameter int PAGES        = 8,
   parameter int CLK_DIV      = 1,
   parameter int STARTUP_WAIT = 10,
   parameter bit CONTINUOUS   = 1'b1,
   parameter int ADDR_W       = $clog2(COLS*PAGES)
) (
   input  logic              clk,
   input  logic              rst_btn,
   output logic              ioSclk,
   output logic              ioSdin,
   output logic              ioCs,
   output logic              ioDc,
   output logic              ioReset,
   output logic [ADDR_W-1:0] pixelAddress,
   input  logic [7:0]        pixelData,
   input  logic              frameStart,
   output logic              busy,
   output logic              frameDone
);

   localparam int NBYTES = COLS*PAGES;
   localparam int N_INIT = 23;
   localparam int N_CMD  = 29;
   localparam int PWR_W  = $clog2(4*STARTUP_WAIT+1);
   localparam int DIV_W  = $clog2(CLK_DIV+1);

   typedef enum logic [2:0] {POWER, LOAD_CMD, SEND, CHECK, IDLE, FETCH, LOAD_DATA} state_t;

   state_t             state;
   logic [PWR_W-1:0]   powerCnt;
   logic [DIV_W-1:0]   divCnt;
   logic [2:0]         bitIdx;
   logic [7:0]         shiftReg;
   logic [4:0]         cmdIdx;
   logic               inData;
   logic               lastByte;
   logic [7:0]         cmdByte;

   // Init list (0..22) followed by the per-frame addressing window (23..28).
   always_comb begin
      cmdByte = 8'h00;
      case (cmdIdx)
         5'd0:  cmdByte = 8'hAE;
         5'd1:  cmdByte = 8'h81;
         5'd2:  cmdByte = 8'h7F;
         5'd3:  cmdByte = 8'hA6;
         5'd4:  cmdByte = 8'h20;
         5'd6:  cmdByte = 8'hC8;
         5'd7:  cmdByte = 8'h40;
         5'd8:  cmdByte = 8'hA1;
         5'd9:  cmdByte = 8'hA8;
         5'd10: cmdByte = 8'(8*PAGES-1);
         5'd11: cmdByte = 8'hD3;
         5'd13: cmdByte = 8'hD5;
         5'd14: cmdByte = 8'h80;
         5'd15: cmdByte = 8'hD9;
         5'd16: cmdByte = 8'h22;
         5'd17: cmdByte = 8'hDB;
         5'd18: cmdByte = 8'h20;
         5'd19: cmdByte = 8'h8D;
         5'd20: cmdByte = 8'h14;
         5'd21: cmdByte = 8'hA4;
         5'd22: cmdByte = 8'hAF;
         5'd23: cmdByte = 8'h21;
         5'd25: cmdByte = 8'(COLS-1);
         5'd26: cmdByte = 8'h22;
         5'd28: cmdByte = 8'(PAGES-1);
         default: cmdByte = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         state        <= POWER;
         ioSclk       <= 1'b1;
         ioSdin       <= 1'b0;
         ioCs         <= 1'b1;
         ioDc         <= 1'b1;
         ioReset      <= 1'b1;
         pixelAddress <= '0;
         busy         <= 1'b1;
         frameDone    <= 1'b0;
         powerCnt     <= '0;
         divCnt       <= '0;
         bitIdx       <= 3'd0;
         shiftReg     <= 8'h00;
         cmdIdx       <= 5'd0;
         inData       <= 1'b0;
         lastByte     <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         case (state)
            POWER: begin
               ioReset <= !(powerCnt >= PWR_W'(2*STARTUP_WAIT) && powerCnt < PWR_W'(3*STARTUP_WAIT));
               if (powerCnt == PWR_W'(4*STARTUP_WAIT-1)) begin
                  powerCnt <= '0;
                  cmdIdx   <= 5'd0;
                  state    <= LOAD_CMD;
               end else begin
                  powerCnt <= powerCnt + PWR_W'(1);
               end
            end
            LOAD_CMD: begin
               ioDc     <= 1'b0;
               ioCs     <= 1'b0;
               shiftReg <= cmdByte;
               ioSdin   <= cmdByte[7];
               ioSclk   <= 1'b0;
               bitIdx   <= 3'd7;
               divCnt   <= '0;
               cmdIdx   <= cmdIdx + 5'd1;
               state    <= SEND;
            end
            SEND: begin
               // Each SCLK level is held CLK_DIV cycles; data changes only on the falling edge.
               if (divCnt != DIV_W'(CLK_DIV-1)) begin
                  divCnt <= divCnt + DIV_W'(1);
               end else begin
                  divCnt <= '0;
                  if (!ioSclk) begin
                     ioSclk <= 1'b1;
                  end else if (bitIdx == 3'd0) begin
                     state <= CHECK;
                  end else begin
                     bitIdx <= bitIdx - 3'd1;
                     ioSclk <= 1'b0;
                     ioSdin <= shiftReg[bitIdx - 3'd1];
                  end
               end
            end
            CHECK: begin
               ioCs <= 1'b1;
               if (!inData) begin
                  if (cmdIdx == 5'(N_INIT)) begin
                     if (CONTINUOUS) begin
                        state <= LOAD_CMD;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else if (cmdIdx == 5'(N_CMD)) begin
                     inData <= 1'b1;
                     state  <= FETCH;
                  end else begin
                     state <= LOAD_CMD;
                  end
               end else if (lastByte) begin
                  // Next frame re-sends the window so the panel pointer is resynchronised.
                  lastByte  <= 1'b0;
                  frameDone <= 1'b1;
                  inData    <= 1'b0;
                  cmdIdx    <= 5'(N_INIT);
                  if (CONTINUOUS) begin
                     state <= LOAD_CMD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  state <= FETCH;
               end
            end
            IDLE: begin
               if (frameStart) begin
                  busy  <= 1'b1;
                  state <= LOAD_CMD;
               end
            end
            FETCH: begin
               ioCs  <= 1'b0;
               state <= LOAD_DATA;
            end
            LOAD_DATA: begin
               ioDc     <= 1'b1;
               ioCs     <= 1'b0;
               shiftReg <= pixelData;
               ioSdin   <= pixelData[7];
               ioSclk   <= 1'b0;
               bitIdx   <= 3'd7;
               divCnt   <= '0;
               if (pixelAddress == ADDR_W'(NBYTES-1)) begin
                  pixelAddress <= '0;
                  lastByte     <= 1'b1;
               end else begin
                  pixelAddress <= pixelAddress + ADDR_W'(1);
               end
               state <= SEND;
            end
            default: state <= POWER;
         endcase
      end
   end

endmodule
